// File: rtl/layer14_acc_bias_relu.sv
// Layer-14 per-lane partial-sum accumulator with bias add, ReLU and
// 18-bit output clamp. Partial sums from the adder tree are accumulated
// over up to N_PASS beats in wide saturating registers; the final beat
// adds the bias, rectifies, clamps and loads a valid/ready output register.
module layer14_acc_bias_relu #(
    parameter int N_adder_tree = 16,
    parameter int W            = 18,
    parameter int ACC_W        = 24,
    parameter int N_PASS       = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_last,
    input  logic [N_adder_tree*W-1:0] psum,
    input  logic [N_adder_tree*W-1:0] bias,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N_adder_tree*W-1:0] out_data,
    output logic                      sat_flag,
    output logic                      seq_err
);

    localparam int CW = $clog2(N_PASS) + 1;
    // Two guard bits: acc + psum + bias can never overflow this width.
    localparam int SW = ACC_W + 2;

    localparam logic [SW-1:0] ACC_MAX_X = {{(SW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic [SW-1:0] ACC_MIN_X = {{(SW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
    localparam logic [SW-1:0] OUT_MAX_X = {{(SW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic [W-1:0]  OUT_MAX   = {1'b0, {(W-1){1'b1}}};

    logic                    out_valid_reg;
    logic                    sat_flag_reg;
    logic                    seq_err_reg;
    logic [CW-1:0]           cnt_reg;

    logic                    accept;
    logic                    cnt_at_max;
    logic                    last_beat;
    logic                    last_accept;
    logic [N_adder_tree-1:0] acc_sat_lane;
    logic [N_adder_tree-1:0] out_sat_lane;

    // Ready depends only on the output register and out_ready, never on in_valid.
    assign in_ready    = !out_valid_reg || out_ready;
    assign accept      = in_valid && in_ready;
    assign cnt_at_max  = (cnt_reg == CW'(N_PASS - 1));
    // A group that reaches N_PASS beats is closed even without in_last.
    assign last_beat   = in_last || cnt_at_max;
    assign last_accept = accept && last_beat;

    assign out_valid = out_valid_reg;
    assign sat_flag  = sat_flag_reg;
    assign seq_err   = seq_err_reg;

    generate
        for (genvar gi = 0; gi < N_adder_tree; gi++) begin : g_lane
            logic [ACC_W-1:0] acc_reg;
            logic [W-1:0]     out_lane_reg;
            logic [W-1:0]     psum_lane;
            logic [W-1:0]     bias_lane;
            logic [SW-1:0]    acc_x;
            logic [SW-1:0]    psum_x;
            logic [SW-1:0]    bias_x;
            logic [SW-1:0]    sum_acc;
            logic [SW-1:0]    sum_fin;
            logic [ACC_W-1:0] acc_next;
            logic [W-1:0]     out_next;
            logic             acc_sat;
            logic             out_sat;

            assign psum_lane = psum[W*gi +: W];
            assign bias_lane = bias[W*gi +: W];
            assign acc_x     = {{(SW-ACC_W){acc_reg[ACC_W-1]}}, acc_reg};
            assign psum_x    = {{(SW-W){psum_lane[W-1]}}, psum_lane};
            assign bias_x    = {{(SW-W){bias_lane[W-1]}}, bias_lane};
            assign sum_acc   = acc_x + psum_x;
            assign sum_fin   = acc_x + psum_x + bias_x;

            // Saturating accumulate for non-final beats.
            always_comb begin
                acc_next = sum_acc[ACC_W-1:0];
                acc_sat  = 1'b0;
                if ($signed(sum_acc) > $signed(ACC_MAX_X)) begin
                    acc_next = ACC_MAX_X[ACC_W-1:0];
                    acc_sat  = 1'b1;
                end else if ($signed(sum_acc) < $signed(ACC_MIN_X)) begin
                    acc_next = ACC_MIN_X[ACC_W-1:0];
                    acc_sat  = 1'b1;
                end
            end

            // ReLU plus positive clamp on the unclamped final sum; zeroing is not a saturation.
            always_comb begin
                out_next = sum_fin[W-1:0];
                out_sat  = 1'b0;
                if (sum_fin[SW-1]) begin
                    out_next = '0;
                end else if ($signed(sum_fin) > $signed(OUT_MAX_X)) begin
                    out_next = OUT_MAX;
                    out_sat  = 1'b1;
                end
            end

            assign acc_sat_lane[gi]    = acc_sat;
            assign out_sat_lane[gi]    = out_sat;
            assign out_data[W*gi +: W] = out_lane_reg;

            // Lane accumulator: accumulate on non-final beats, clear when the group closes.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    acc_reg <= '0;
                end else if (accept) begin
                    acc_reg <= last_beat ? '0 : acc_next;
                end
            end

            // Lane output register: loads only when a group closes, holds otherwise.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_lane_reg <= '0;
                end else if (last_accept) begin
                    out_lane_reg <= out_next;
                end
            end
        end
    endgenerate

    // Beat counter, output valid and sticky status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg       <= '0;
            out_valid_reg <= 1'b0;
            sat_flag_reg  <= 1'b0;
            seq_err_reg   <= 1'b0;
        end else begin
            if (accept) begin
                cnt_reg <= last_beat ? '0 : cnt_reg + CW'(1);
            end
            // A new group loading in the same cycle as a handshake keeps valid high.
            if (last_accept) begin
                out_valid_reg <= 1'b1;
            end else if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
            end
            if ((accept && !last_beat && |acc_sat_lane) ||
                (last_accept && |out_sat_lane)) begin
                sat_flag_reg <= 1'b1;
            end
            if (accept && cnt_at_max && !in_last) begin
                seq_err_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_layer14_acc_bias_relu.sv
// Bench for layer14_acc_bias_relu: two instances (ACC_W=24 and ACC_W=19)
// share one stimulus stream; each is checked against an integer model of
// the accumulate / bias / ReLU / clamp rules.
module tb_layer14_acc_bias_relu;

    localparam int N    = 16;
    localparam int W    = 18;
    localparam int NP   = 4;
    localparam int OMAX = 131071;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid, in_last, out_ready;
    logic [N*W-1:0] psum, bias;
    logic           in_ready_a, out_valid_a, sat_a, seq_a;
    logic [N*W-1:0] out_a;
    logic           in_ready_b, out_valid_b, sat_b, seq_b;
    logic [N*W-1:0] out_b;

    always #5 clk = ~clk;

    layer14_acc_bias_relu #(.N_adder_tree(N), .W(W), .ACC_W(24), .N_PASS(NP)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_last(in_last), .psum(psum), .bias(bias), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_data(out_a), .sat_flag(sat_a), .seq_err(seq_a));

    layer14_acc_bias_relu #(.N_adder_tree(N), .W(W), .ACC_W(19), .N_PASS(NP)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_last(in_last), .psum(psum), .bias(bias), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_data(out_b), .sat_flag(sat_b), .seq_err(seq_b));

    int total = 0;
    int bad   = 0;
    int pv[N];
    int bv[N];

    // Reference model state, index 0 = ACC_W 24, index 1 = ACC_W 19.
    longint m_acc[2][N];
    int     m_cnt[2];
    bit     m_ov[2];
    int     m_out[2][N];
    bit     m_sat[2];
    bit     m_seq[2];

    function automatic int acc_w(int k);
        return (k == 0) ? 24 : 19;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_ov[k] = 0; m_sat[k] = 0; m_seq[k] = 0;
            for (int i = 0; i < N; i++) begin
                m_acc[k][i] = 0;
                m_out[k][i] = 0;
            end
        end
    endfunction

    // One clock edge of the model, given the inputs held across that edge.
    function automatic void model_edge(bit v, bit l, bit ordy);
        for (int k = 0; k < 2; k++) begin
            bit     took;
            bit     fin;
            longint amax;
            longint amin;
            longint s;
            took = v && (!m_ov[k] || ordy);
            amax = (longint'(1) << (acc_w(k) - 1)) - 1;
            amin = -amax - 1;
            if (m_ov[k] && ordy) m_ov[k] = 0;
            if (took) begin
                fin = l || (m_cnt[k] == NP - 1);
                if (!l && m_cnt[k] == NP - 1) m_seq[k] = 1;
                for (int i = 0; i < N; i++) begin
                    if (fin) begin
                        s = m_acc[k][i] + pv[i] + bv[i];
                        if (s < 0) m_out[k][i] = 0;
                        else if (s > OMAX) begin m_out[k][i] = OMAX; m_sat[k] = 1; end
                        else m_out[k][i] = int'(s);
                        m_acc[k][i] = 0;
                    end else begin
                        s = m_acc[k][i] + pv[i];
                        if (s > amax) begin s = amax; m_sat[k] = 1; end
                        if (s < amin) begin s = amin; m_sat[k] = 1; end
                        m_acc[k][i] = s;
                    end
                end
                if (fin) begin
                    m_cnt[k] = 0;
                    m_ov[k]  = 1;
                end else begin
                    m_cnt[k] = m_cnt[k] + 1;
                end
            end
        end
    endfunction

    function automatic logic [N*W-1:0] model_pack(int k);
        logic [N*W-1:0] r;
        int             x;
        for (int i = 0; i < N; i++) begin
            x = m_out[k][i];
            r[i*W +: W] = x[W-1:0];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs();
        chk("out_valid_a", out_valid_a, m_ov[0]);
        chk("out_valid_b", out_valid_b, m_ov[1]);
        chk("out_data_a", out_a, model_pack(0));
        chk("out_data_b", out_b, model_pack(1));
        chk("sat_flag_a", sat_a, m_sat[0]);
        chk("sat_flag_b", sat_b, m_sat[1]);
        chk("seq_err_a", seq_a, m_seq[0]);
        chk("seq_err_b", seq_b, m_seq[1]);
    endtask

    task automatic rand_psum(input int lim);
        for (int i = 0; i < N; i++) pv[i] = int'($urandom_range(2 * lim, 0)) - lim;
    endtask

    task automatic rand_bias(input int lim);
        for (int i = 0; i < N; i++) bv[i] = int'($urandom_range(2 * lim, 0)) - lim;
    endtask

    // Present one cycle of inputs, check ready, then check registered outputs after the edge.
    task automatic step(input bit v, input bit l, input bit ordy, output bit took);
        bit exp_ready;
        @(negedge clk);
        in_valid  = v;
        in_last   = l;
        out_ready = ordy;
        for (int i = 0; i < N; i++) begin
            psum[i*W +: W] = pv[i][W-1:0];
            bias[i*W +: W] = bv[i][W-1:0];
        end
        #1;
        exp_ready = !m_ov[0] || ordy;
        chk("in_ready_a", in_ready_a, exp_ready);
        chk("in_ready_b", in_ready_b, exp_ready);
        took = v && exp_ready;
        @(posedge clk);
        model_edge(v, l, ordy);
        #1;
        check_outputs();
        $display("beat v=%0b last=%0b out_ready=%0b accepted=%0b out_valid=%0b lane0=%0d",
                 v, l, ordy, took, out_valid_a, $signed(out_a[W-1:0]));
    endtask

    // Present one beat until it is accepted, with a bounded number of tries.
    task automatic send(input bit l, input bit rand_ready);
        bit took;
        int tries;
        took  = 0;
        tries = 0;
        while (!took && tries < 20) begin
            step(1'b1, l, rand_ready ? 1'($urandom_range(1, 0)) : 1'b1, took);
            tries++;
        end
        total++;
        assert (took) else begin
            bad++;
            $error("FAIL send_timeout observed=%0d expected=accepted", tries);
        end
    endtask

    task automatic do_reset();
        bit took;
        @(negedge clk);
        #2;
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("rst_out_valid", out_valid_a, 1'b0);
        chk("rst_out_data", out_a, '0);
        chk("rst_out_data_b", out_b, '0);
        chk("rst_sat", sat_a, 1'b0);
        chk("rst_seq", seq_a, 1'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0, took);
        chk("rst_in_ready", in_ready_a, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit             took;
        logic [N*W-1:0] held;
        int             lane0[4];

        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        psum = '0; bias = '0;
        for (int i = 0; i < N; i++) begin pv[i] = 0; bv[i] = 0; end
        model_reset();
        #12;
        chk("reset_out_valid", out_valid_a, 1'b0);
        chk("reset_out_data", out_a, '0);
        chk("reset_sat", sat_b, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b1, took);
        chk("reset_in_ready", in_ready_a, 1'b1);

        // Four-pass group: lane 0 directed, lane 1 ReLU to zero, others small random.
        lane0 = '{100, 200, -50, 30};
        rand_bias(10000);
        bv[0] = 5428; bv[1] = -1000;
        for (int b = 0; b < 4; b++) begin
            rand_psum(10000);
            pv[0] = lane0[b];
            pv[1] = -17500;
            send(b == 3, 1'b0);
        end
        chk("lane0_5708_a", out_a[0 +: W], 18'd5708);
        chk("lane0_5708_b", out_b[0 +: W], 18'd5708);
        chk("lane1_relu", out_a[W +: W], 18'd0);
        chk("relu_no_sat", sat_a, 1'b0);

        // Accumulator clamp visible only in the narrow instance.
        rand_bias(10000);
        bv[3] = -131072;
        for (int b = 0; b < 4; b++) begin
            rand_psum(10000);
            pv[3] = (b == 3) ? -131072 : 131071;
            send(b == 3, 1'b0);
        end
        chk("accclamp_wide", out_a[3*W +: W], 18'd131069);
        chk("accclamp_narrow", out_b[3*W +: W], 18'd0);
        chk("accclamp_sat_b", sat_b, 1'b1);
        chk("accclamp_sat_a", sat_a, 1'b0);

        // Positive output clamp on lane 2.
        rand_bias(131072);
        bv[2] = 131071;
        for (int b = 0; b < 3; b++) begin
            rand_psum(131072);
            pv[2] = 131071;
            send(b == 2, 1'b0);
        end
        chk("lane2_clamp", out_a[2*W +: W], 18'd131071);
        chk("lane2_sat", sat_a, 1'b1);

        // Four beats of full-scale on lane 3.
        rand_bias(131072);
        bv[3] = 0;
        for (int b = 0; b < 4; b++) begin
            rand_psum(131072);
            pv[3] = 131071;
            send(b == 3, 1'b0);
        end
        chk("lane3_acc19", out_b[3*W +: W], 18'd131071);

        // Sequence error: four beats without in_last, then a fresh group.
        chk("seq_before", seq_a, 1'b0);
        for (int b = 0; b < 4; b++) begin
            rand_psum(131072);
            send(1'b0, 1'b0);
        end
        chk("seq_out_valid", out_valid_a, 1'b1);
        chk("seq_err_set", seq_a, 1'b1);
        for (int b = 0; b < 4; b++) begin
            rand_psum(131072);
            send(b == 3, 1'b0);
        end

        // Backpressure: output pending, out_ready low for five cycles.
        rand_psum(20000);
        send(1'b1, 1'b0);
        held = out_a;
        rand_psum(20000);
        for (int c = 0; c < 5; c++) begin
            step(1'b1, 1'b0, 1'b0, took);
            chk("bp_in_ready", in_ready_a, 1'b0);
            chk("bp_stable", out_a, held);
        end
        send(1'b0, 1'b0);
        for (int b = 0; b < 6; b++) begin
            rand_psum(20000);
            send(1'b1, 1'b0);
            chk("stream_no_bubble", out_valid_a, 1'b1);
        end

        // Asynchronous reset while an output is pending.
        step(1'b0, 1'b0, 1'b0, took);
        do_reset();

        // Reset in the middle of a group discards the partial sums.
        for (int b = 0; b < 2; b++) begin
            rand_psum(131072);
            send(1'b0, 1'b0);
        end
        do_reset();
        for (int b = 0; b < 2; b++) begin
            rand_psum(131072);
            send(b == 1, 1'b0);
        end

        // Random groups with random downstream readiness.
        for (int g = 0; g < 20; g++) begin
            int len;
            len = int'($urandom_range(NP, 1));
            rand_bias(131072);
            for (int b = 0; b < len; b++) begin
                rand_psum(131072);
                send(b == len - 1 && $urandom_range(3, 0) != 0, 1'b1);
            end
        end
        step(1'b0, 1'b0, 1'b1, took);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
